ctrl_pipeline: RTL and testbench

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

---
 rtl/lc3b_types.sv | 56 +++++
 rtl/ctrl_stage.sv | 42 ++++
 rtl/ctrl_pipeline.sv | 74 +++++++
 tb/tb_ctrl_pipeline.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Control-word types for the LC-3b decode pipeline and the canonical NOP word.
// Combinational definitions only; no latency or flow control.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'h0, op_add = 4'h1, op_ldb = 4'h2, op_stb = 4'h3,
        op_jsr  = 4'h4, op_and = 4'h5, op_ldr = 4'h6, op_str = 4'h7,
        op_rti  = 4'h8, op_not = 4'h9, op_ldi = 4'ha, op_sti = 4'hb,
        op_jmp  = 4'hc, op_shf = 4'hd, op_lea = 4'he, op_trap = 4'hf
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;

    typedef struct packed {
        lc3b_opcode opcode;
        lc3b_aluop  aluop;
        logic       load_cc;
        logic       load_regfile;
        logic       load_mar;
        logic       load_mdr;
        logic       mem_read;
        logic       mem_write;
        logic       filter_en;
        logic       indirect;
        logic       imm_en;
        logic [1:0] pcmux_sel;
        logic       alumux_sel;
        logic [1:0] regfilemux_sel;
        logic       marmux_sel;
        logic [1:0] mem_byte_enable;
        logic       is_nop;
    } lc3b_control_word;

    localparam lc3b_control_word CTRL_NOP = '{
        opcode:          op_add,
        aluop:           alu_add,
        load_cc:         1'b0,
        load_regfile:    1'b0,
        load_mar:        1'b0,
        load_mdr:        1'b0,
        mem_read:        1'b0,
        mem_write:       1'b0,
        filter_en:       1'b0,
        indirect:        1'b0,
        imm_en:          1'b0,
        pcmux_sel:       2'b00,
        alumux_sel:      1'b0,
        regfilemux_sel:  2'b00,
        marmux_sel:      1'b0,
        mem_byte_enable: 2'b11,
        is_nop:          1'b1
    };

endpackage

// File: rtl/ctrl_stage.sv
// One control-word pipeline register: kill > hold > bubble > load, 1-cycle latency.
// Backpressure arrives as frz (hold) and bubble (upstream frozen, insert NOP).
module ctrl_stage
    import lc3b_types::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              kill,
    input  logic              frz,
    input  logic              bubble,
    input  lc3b_control_word  prev_word,
    input  logic [DATA_W-1:0] prev_data,
    input  logic              prev_valid,
    output lc3b_control_word  word,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    always_ff @(posedge clk) begin
        if (!reset_n || kill) begin
            word  <= CTRL_NOP;
            data  <= '0;
            valid <= 1'b0;
        end else if (frz) begin
            word  <= word;
            data  <= data;
            valid <= valid;
        end else if (bubble) begin
            word  <= CTRL_NOP;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            // Invalid entries are normalised to NOP so out_word never leaks junk.
            word  <= prev_valid ? prev_word : CTRL_NOP;
            data  <= prev_data;
            valid <= prev_valid;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// STAGES-deep control-word pipeline with per-stage stall/flush and a bubble counter.
// Word reaches stage k k+1 cycles after acceptance; in_ready drops on any stall bit.
module ctrl_pipeline
    import lc3b_types::*;
#(
    parameter int STAGES = 4,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  lc3b_control_word  in_word,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [STAGES-1:0] stall,
    input  logic [STAGES-1:0] flush,
    output lc3b_control_word  out_word [STAGES],
    output logic [DATA_W-1:0] out_data [STAGES],
    output logic [STAGES-1:0] out_valid,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] frz;

    assign in_ready = ~|stall;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        // A stall or flush downstream also covers every upstream stage.
        assign kill[i] = |flush[STAGES-1:i];
        assign frz[i]  = |stall[STAGES-1:i];

        if (i == 0) begin : g_head
            ctrl_stage #(.DATA_W(DATA_W)) u_stage (
                .clk        (clk),
                .reset_n    (reset_n),
                .kill       (kill[i]),
                .frz        (frz[i]),
                .bubble     (1'b0),
                .prev_word  (in_word),
                .prev_data  (in_data),
                .prev_valid (in_valid),
                .word       (out_word[i]),
                .data       (out_data[i]),
                .valid      (out_valid[i])
            );
        end else begin : g_body
            ctrl_stage #(.DATA_W(DATA_W)) u_stage (
                .clk        (clk),
                .reset_n    (reset_n),
                .kill       (kill[i]),
                .frz        (frz[i]),
                .bubble     (frz[i-1]),
                .prev_word  (out_word[i-1]),
                .prev_data  (out_data[i-1]),
                .prev_valid (out_valid[i-1]),
                .word       (out_word[i]),
                .data       (out_data[i]),
                .valid      (out_valid[i])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || cnt_clr) begin
            bubble_cnt <= '0;
        end else if (!out_valid[STAGES-1] && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Self-checking bench for ctrl_pipeline: scoreboard on the last stage plus directed stall/flush/reset cases.
module tb_ctrl_pipeline;
    import lc3b_types::*;

    localparam int ST = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    lc3b_control_word in_word;
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [ST-1:0]    stall;
    logic [ST-1:0]    flush;
    lc3b_control_word out_word [ST];
    logic [15:0]      out_data [ST];
    logic [ST-1:0]    out_valid;
    logic             cnt_clr;
    logic [15:0]      bubble_cnt;

    logic             s_in_ready;
    lc3b_control_word s_out_word [ST];
    logic [15:0]      s_out_data [ST];
    logic [ST-1:0]    s_out_valid;
    logic [3:0]       s_bubble_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        lc3b_control_word w;
        logic [15:0]      d;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    ctrl_pipeline #(.STAGES(ST), .DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_word(in_word), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .stall(stall), .flush(flush),
        .out_word(out_word), .out_data(out_data), .out_valid(out_valid),
        .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
    );

    ctrl_pipeline #(.STAGES(ST), .DATA_W(16), .CNT_W(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .in_word(in_word), .in_data(in_data),
        .in_valid(in_valid), .in_ready(s_in_ready), .stall(stall), .flush(flush),
        .out_word(s_out_word), .out_data(s_out_data), .out_valid(s_out_valid),
        .cnt_clr(cnt_clr), .bubble_cnt(s_bubble_cnt)
    );

    function automatic lc3b_control_word mk_word(input logic [15:0] d);
        lc3b_control_word w;
        w              = CTRL_NOP;
        w.opcode       = lc3b_opcode'(d[3:0]);
        w.load_regfile = 1'b1;
        w.imm_en       = d[1];
        w.is_nop       = 1'b0;
        return w;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive stage-0 inputs; a word is expected downstream only if stall is clear.
    task automatic drive(input logic v, input logic [15:0] d);
        exp_t e;
        in_valid = v;
        in_data  = d;
        in_word  = mk_word(d);
        if (v && stall == '0 && flush == '0) begin
            e.w = mk_word(d);
            e.d = d;
            sb.push_back(e);
        end
    endtask

    task automatic mon3;
        exp_t e;
        if (out_valid[3]) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: stage3 data %h with no expected word", out_data[3]);
            end else begin
                e = sb.pop_front();
                if (out_data[3] !== e.d || out_word[3] !== e.w) begin
                    errors++;
                    $display("FAIL sb_stage3: got %h/%h expected %h/%h", out_data[3], out_word[3], e.d, e.w);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; stall = '0; flush = '0; cnt_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; in_word = CTRL_NOP;
        tick; tick;
        checks++;
        if (out_valid !== 4'b0000 || bubble_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_state: valid %b cnt %0d expected 0000/0", out_valid, bubble_cnt);
        end
        for (int i = 0; i < ST; i++) begin
            checks++;
            if (out_word[i] !== CTRL_NOP || out_data[i] !== 16'h0) begin
                errors++; $display("FAIL reset_word%0d: got %h/%h expected %h/0", i, out_word[i], out_data[i], CTRL_NOP);
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_stream;
        sb.delete();
        for (int k = 0; k < 10; k++) begin
            if (k < 6) drive(1'b1, 16'(16'h3000 + 2 * k));
            else       drive(1'b0, 16'h0);
            if (k == 0) reset_n = 1'b1;
            tick;
            mon3;
            if (k == 3) begin
                checks++;
                if (out_data[3] !== 16'h3000 || bubble_cnt !== 16'd4) begin
                    errors++; $display("FAIL stream_latency: data %h cnt %0d expected 3000/4", out_data[3], bubble_cnt);
                end
            end
            if (k >= 3 && k <= 8) begin
                checks++;
                if (out_valid[3] !== 1'b1) begin
                    errors++; $display("FAIL stream_valid3 k=%0d: got %b expected 1", k, out_valid[3]);
                end
            end
        end
        checks++;
        if (bubble_cnt !== 16'd4 || sb.size() != 0) begin
            errors++; $display("FAIL stream_end: cnt %0d left %0d expected 4/0", bubble_cnt, sb.size());
        end
    endtask

    task automatic test_stall;
        logic [15:0] held [3];
        logic [15:0] base;
        base = '0;
        for (int c = 0; c < 12; c++) begin
            stall = (c == 6 || c == 7) ? 4'b0100 : 4'b0000;
            drive(1'b1, 16'(16'h3100 + c));
            #1;
            if (stall != '0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready c=%0d: got %b expected 0", c, in_ready);
                end
            end
            if (c == 6) begin
                held[0] = 16'h3105; held[1] = 16'h3104; held[2] = 16'h3103;
                base = bubble_cnt;
            end
            tick;
            mon3;
            if (c == 6 || c == 7) begin
                for (int j = 0; j < 3; j++) begin
                    checks++;
                    if (out_data[j] !== held[j] || out_valid[j] !== 1'b1) begin
                        errors++; $display("FAIL stall_hold%0d c=%0d: got %h expected %h", j, c, out_data[j], held[j]);
                    end
                end
                checks++;
                if (out_valid[3] !== 1'b0 || out_word[3] !== CTRL_NOP) begin
                    errors++; $display("FAIL stall_bubble c=%0d: got %b/%h expected 0/%h", c, out_valid[3], out_word[3], CTRL_NOP);
                end
            end
        end
        checks++;
        if (bubble_cnt !== 16'(base + 16'd2)) begin
            errors++; $display("FAIL stall_cnt: got %0d expected %0d", bubble_cnt, base + 16'd2);
        end
        stall = '0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0);
            tick;
            mon3;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL stall_drain: %0d words never appeared, expected 0", sb.size());
        end
    endtask

    task automatic test_flush_stall;
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'(16'h3200 + k));
            tick;
        end
        sb.delete();
        flush = 4'b0010; stall = 4'b0100;
        drive(1'b1, 16'h3204);
        tick;
        checks++;
        if (out_valid[1:0] !== 2'b00 || out_word[0] !== CTRL_NOP || out_word[1] !== CTRL_NOP || out_data[1] !== 16'h0) begin
            errors++; $display("FAIL flush_kill: valid %b w0 %h w1 %h d1 %h expected 00/NOP/NOP/0", out_valid[1:0], out_word[0], out_word[1], out_data[1]);
        end
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[2] !== 16'h3201) begin
            errors++; $display("FAIL flush_hold2: got %b/%h expected 1/3201", out_valid[2], out_data[2]);
        end
        checks++;
        if (out_valid[3] !== 1'b0 || out_word[3] !== CTRL_NOP) begin
            errors++; $display("FAIL flush_bubble3: got %b/%h expected 0/%h", out_valid[3], out_word[3], CTRL_NOP);
        end
        flush = 4'b0001; stall = 4'b0000;
        drive(1'b1, 16'h3300);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready);
        end
        tick;
        checks++;
        if (out_valid[0] !== 1'b0 || out_data[0] !== 16'h0 || out_valid[3] !== 1'b1 || out_data[3] !== 16'h3201) begin
            errors++; $display("FAIL flush_discard: v0 %b d0 %h v3 %b d3 %h expected 0/0/1/3201", out_valid[0], out_data[0], out_valid[3], out_data[3]);
        end
        flush = '0;
        sb.delete();
        drive(1'b0, 16'h0);
    endtask

    task automatic test_invalid_word;
        in_valid = 1'b0;
        in_data  = 16'h1234;
        in_word  = mk_word(16'h1234);
        tick;
        checks++;
        if (out_word[0] !== CTRL_NOP || out_valid[0] !== 1'b0) begin
            errors++; $display("FAIL invalid_word: got %h/%b expected %h/0", out_word[0], out_valid[0], CTRL_NOP);
        end
        in_word = CTRL_NOP;
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 4; k++) tick;
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        checks++;
        if (bubble_cnt !== 16'd0 || s_bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL clr_priority: got %0d/%0d expected 0/0", bubble_cnt, s_bubble_cnt);
        end
        for (int k = 0; k < 20; k++) tick;
        checks++;
        if (s_bubble_cnt !== 4'd15) begin
            errors++; $display("FAIL saturate: got %0d expected 15", s_bubble_cnt);
        end
        checks++;
        if (bubble_cnt !== 16'd20) begin
            errors++; $display("FAIL idle_count: got %0d expected 20", bubble_cnt);
        end
        cnt_clr = 1'b1;
        tick;
        cnt_clr = 1'b0;
        checks++;
        if (bubble_cnt !== 16'd0 || s_bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL clr_after_sat: got %0d/%0d expected 0/0", bubble_cnt, s_bubble_cnt);
        end
    endtask

    task automatic test_reset_stall;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'(16'h3400 + k));
            tick;
        end
        sb.delete();
        stall = 4'b1000;
        drive(1'b1, 16'h3404);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_stall_ready: got %b expected 0", in_ready);
        end
        tick;
        checks++;
        if (out_data[3] !== 16'h3400 || out_data[0] !== 16'h3403) begin
            errors++; $display("FAIL rst_stall_hold: got %h/%h expected 3400/3403", out_data[3], out_data[0]);
        end
        reset_n = 1'b0;
        flush = 4'b0010;
        tick;
        checks++;
        if (out_valid !== 4'b0000 || bubble_cnt !== 16'd0 || s_bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL rst_mid_stall: valid %b cnt %0d/%0d expected 0000/0/0", out_valid, bubble_cnt, s_bubble_cnt);
        end
        for (int i = 0; i < ST; i++) begin
            checks++;
            if (out_word[i] !== CTRL_NOP || out_data[i] !== 16'h0) begin
                errors++; $display("FAIL rst_mid_stall_word%0d: got %h/%h expected %h/0", i, out_word[i], out_data[i], CTRL_NOP);
            end
        end
        reset_n = 1'b1; stall = '0; flush = '0;
        drive(1'b0, 16'h0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready);
        end
        tick;
        checks++;
        if (bubble_cnt !== 16'd1 || out_valid !== 4'b0000) begin
            errors++; $display("FAIL rst_release_first: cnt %0d valid %b expected 1/0000", bubble_cnt, out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_flush_stall;
        test_invalid_word;
        test_saturate;
        test_reset_stall;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
